clk_div_multi: RTL

Multi-channel programmable clock-enable and divided-clock generator: the successor to the fixed single-output 1 Hz divider. Each of NCH channels has a runtime-loadable divisor, an enable, and a mode selecting square-wave or single-cycle-pulse output. Divisor changes are glitch-free, and a global sync input phase-aligns all channels. It sits next to the board clock and feeds display scan, debounce sampling and seconds counters in the lab designs.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_chan.sv | 79 +++++++
 rtl/clk_div_multi.sv | 49 ++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
package clk_div_pkg;

  localparam int unsigned CLK_HZ  = 100_000_000;
  localparam int unsigned DEF_DIV = 50_000_000;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Divisor giving a square wave of the requested frequency (two ticks per period).
  function automatic int unsigned div_for_hz(input int unsigned hz);
    if (hz == 0) return 1;
    return CLK_HZ / (2 * hz);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active divisor pair, toggle bit and
// registered tick / clk_out outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CW      = 32,
  parameter int unsigned DEF_DIV = 50_000_000
)(
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          mode,
  input  logic          wr,
  input  logic [CW-1:0] wr_val,
  input  logic          sync,
  output logic          tick,
  output logic          clk_out
);

  localparam logic [CW-1:0] RST_DIV = (DEF_DIV == 0) ? CW'(1) : CW'(DEF_DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] act_div;
  logic [CW-1:0] shd_div;
  logic          pend;
  logic          tog;

  logic [CW-1:0] wr_div;
  logic [CW-1:0] nxt_shd;
  logic          nxt_pend;
  logic          term;
  logic          load;
  logic          nxt_tick;
  logic          nxt_tog;

  // A write landing on the same edge as a reload point is folded in directly,
  // so the new divisor never waits an extra period.
  always_comb begin
    wr_div   = (wr_val == '0) ? CW'(1) : wr_val;
    nxt_shd  = wr ? wr_div : shd_div;
    nxt_pend = wr | pend;
    term     = en && (cnt == act_div - CW'(1));
    load     = sync || !en || term;
    nxt_tick = 1'b0;
    nxt_tog  = tog;
    if (sync || !en) begin
      nxt_tog = 1'b0;
    end else if (term) begin
      nxt_tick = 1'b1;
      nxt_tog  = ~tog;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      act_div <= RST_DIV;
      shd_div <= RST_DIV;
      pend    <= 1'b0;
      tog     <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      shd_div <= nxt_shd;
      if (load && nxt_pend) begin
        act_div <= nxt_shd;
        pend    <= 1'b0;
      end else begin
        pend    <= nxt_pend;
      end
      if (sync || !en || term) cnt <= '0;
      else                     cnt <= cnt + CW'(1);
      tog     <= nxt_tog;
      tick    <= nxt_tick;
      clk_out <= (mode == MODE_PULSE) ? nxt_tick : nxt_tog;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable / divided-clock generator: decodes
// divisor writes and fans out clock, reset and sync to NCH channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NCH     = 4,
  parameter int          CW      = 32,
  parameter int unsigned DEF_DIV = clk_div_pkg::DEF_DIV
)(
  input  logic                                   sysclk,
  input  logic                                   rst_n,
  input  logic [NCH-1:0]                         en,
  input  logic [NCH-1:0]                         mode,
  input  logic                                   div_wr,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] div_sel,
  input  logic [CW-1:0]                          div_val,
  input  logic                                   sync,
  output logic [NCH-1:0]                         tick,
  output logic [NCH-1:0]                         clk_out
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic sel_ok;

  // Out-of-range selects (non power-of-two NCH) are dropped here.
  assign sel_ok = ({1'b0, div_sel} < (SW + 1)'(NCH));

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic wr;
    assign wr = div_wr && sel_ok && (div_sel == SW'(i));

    clk_div_chan #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .sysclk  (sysclk),
      .rst_n   (rst_n),
      .en      (en[i]),
      .mode    (mode[i]),
      .wr      (wr),
      .wr_val  (div_val),
      .sync    (sync),
      .tick    (tick[i]),
      .clk_out (clk_out[i])
    );
  end

endmodule
